// File: rtl/exu_wbu.sv
// exu_wbu: write-back unit tracking one instruction from issue to retirement,
// driving register-file, CSR, redirect and trap strobes.
module exu_wbu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rf_wen,
  input  logic [2:0]  issue_wbsel,
  input  logic        issue_word,
  input  logic        issue_csr_wen,
  input  logic [11:0] issue_csr_addr,
  input  logic [63:0] issue_pc,
  input  logic        exu_finish,
  input  logic [63:0] alu_out,
  input  logic [63:0] br_out,
  input  logic [63:0] div_out,
  input  logic [63:0] rem_out,
  input  logic [63:0] mul_out,
  input  logic        redirect_valid,
  input  logic [63:0] csr_wdata_rd,
  input  logic [63:0] csr_wdata,
  input  logic [63:0] exu_exception,
  input  logic        flush,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc,
  output logic        trap_valid,
  output logic [63:0] trap_cause,
  output logic        commit_valid,
  input  logic        commit_ready,
  output logic [63:0] commit_pc,
  output logic [63:0] instret,
  output logic        hang
);
  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;
  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        lrf_q, lrf_d, word_q, word_d, lcsr_q, lcsr_d;
  logic [2:0]  wbsel_q, wbsel_d;
  logic [11:0] caddr_q, caddr_d;
  logic [63:0] pc_q, pc_d, res_q, res_d, br_q, br_d, cwd_q, cwd_d, exc_q, exc_d;
  logic [63:0] instret_q, instret_d;
  logic        redir_q, redir_d, first_q, first_d, hang_q, hang_d;
  logic [31:0] tmo_q, tmo_d, tmo_inc;
  logic [63:0] sel;
  logic        acc, ok;
  always_comb begin
    issue_ready = (state_q == IDLE) || (state_q == COMMIT && commit_ready);
    acc = issue_valid && issue_ready;
    tmo_inc = tmo_q + 32'd1;
    sel = wbsel_q == 3'd0 ? (word_q ? {{32{alu_out[31]}}, alu_out[31:0]} : alu_out) :
          wbsel_q == 3'd1 ? pc_q + 64'd4 :
          wbsel_q == 3'd2 ? div_out :
          wbsel_q == 3'd3 ? rem_out :
          wbsel_q == 3'd4 ? mul_out :
          wbsel_q == 3'd5 ? csr_wdata_rd : 64'd0;
    state_d = state_q;
    rd_d = rd_q;
    lrf_d = lrf_q;
    word_d = word_q;
    lcsr_d = lcsr_q;
    wbsel_d = wbsel_q;
    caddr_d = caddr_q;
    pc_d = pc_q;
    res_d = res_q;
    br_d = br_q;
    cwd_d = cwd_q;
    exc_d = exc_q;
    redir_d = redir_q;
    hang_d = hang_q;
    tmo_d = tmo_q;
    first_d = 1'b0;
    instret_d = (state_q == COMMIT && commit_ready && exc_q == 64'd0) ? instret_q + 64'd1 : instret_q;
    case (state_q)
      WAIT: begin
        tmo_d = tmo_inc;
        if (flush) state_d = IDLE;
        else if (exu_finish) begin
          res_d = sel;
          redir_d = redirect_valid;
          br_d = br_out;
          cwd_d = csr_wdata;
          exc_d = exu_exception;
          first_d = 1'b1;
          state_d = COMMIT;
        end else if (tmo_inc >= 32'(TIMEOUT)) begin
          hang_d = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: state_d = commit_ready ? IDLE : COMMIT;
      default: state_d = IDLE;
    endcase
    // a handshake can only happen in IDLE or COMMIT, so it overrides both
    if (acc) begin
      rd_d = issue_rd;
      lrf_d = issue_rf_wen;
      word_d = issue_word;
      lcsr_d = issue_csr_wen;
      wbsel_d = issue_wbsel;
      caddr_d = issue_csr_addr;
      pc_d = issue_pc;
      tmo_d = 32'd0;
      state_d = WAIT;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rd_q <= '0;
      lrf_q <= 1'b0;
      word_q <= 1'b0;
      lcsr_q <= 1'b0;
      wbsel_q <= '0;
      caddr_q <= '0;
      pc_q <= '0;
      res_q <= '0;
      br_q <= '0;
      cwd_q <= '0;
      exc_q <= '0;
      redir_q <= 1'b0;
      first_q <= 1'b0;
      hang_q <= 1'b0;
      tmo_q <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      lrf_q <= lrf_d;
      word_q <= word_d;
      lcsr_q <= lcsr_d;
      wbsel_q <= wbsel_d;
      caddr_q <= caddr_d;
      pc_q <= pc_d;
      res_q <= res_d;
      br_q <= br_d;
      cwd_q <= cwd_d;
      exc_q <= exc_d;
      redir_q <= redir_d;
      first_q <= first_d;
      hang_q <= hang_d;
      tmo_q <= tmo_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    ok = state_q == COMMIT && first_q && exc_q == 64'd0;
    rf_wen = ok && lrf_q && rd_q != 5'd0;
    rf_waddr = rd_q;
    rf_wdata = res_q;
    csr_wen = ok && lcsr_q;
    csr_waddr = caddr_q;
    csr_wdata_o = cwd_q;
    redirect_o = ok && redir_q;
    redirect_pc = br_q;
    trap_valid = state_q == COMMIT && first_q && exc_q != 64'd0;
    trap_cause = exc_q;
    commit_valid = state_q == COMMIT;
    commit_pc = pc_q;
    instret = instret_q;
    hang = hang_q;
  end
endmodule

// File: tb/tb_exu_wbu.sv
// tb_exu_wbu: directed checks of the write-back unit with a short hang timeout.
module tb_exu_wbu;
  logic        clk = 1'b0, rst = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [4:0]  issue_rd = '0;
  logic        issue_rf_wen = 1'b0, issue_word = 1'b0, issue_csr_wen = 1'b0;
  logic [2:0]  issue_wbsel = '0;
  logic [11:0] issue_csr_addr = '0;
  logic [63:0] issue_pc = '0;
  logic        exu_finish = 1'b0, redirect_valid = 1'b0, flush = 1'b0, commit_ready = 1'b0;
  logic [63:0] alu_out = '0, br_out = '0, div_out = '0, rem_out = '0, mul_out = '0;
  logic [63:0] csr_wdata_rd = '0, csr_wdata = '0, exu_exception = '0;
  logic        rf_wen, csr_wen, redirect_o, trap_valid, commit_valid, hang;
  logic [4:0]  rf_waddr;
  logic [11:0] csr_waddr;
  logic [63:0] rf_wdata, csr_wdata_o, redirect_pc, trap_cause, commit_pc, instret;
  int n_chk = 0, n_fail = 0;

  exu_wbu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_rf_wen(issue_rf_wen), .issue_wbsel(issue_wbsel),
    .issue_word(issue_word), .issue_csr_wen(issue_csr_wen), .issue_csr_addr(issue_csr_addr),
    .issue_pc(issue_pc), .exu_finish(exu_finish), .alu_out(alu_out), .br_out(br_out),
    .div_out(div_out), .rem_out(rem_out), .mul_out(mul_out), .redirect_valid(redirect_valid),
    .csr_wdata_rd(csr_wdata_rd), .csr_wdata(csr_wdata), .exu_exception(exu_exception),
    .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata_o(csr_wdata_o),
    .redirect_o(redirect_o), .redirect_pc(redirect_pc), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .instret(instret), .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic rfw, input logic [2:0] wb,
                       input logic wd, input logic cw, input logic [11:0] ca, input logic [63:0] pc);
    issue_rd = rd; issue_rf_wen = rfw; issue_wbsel = wb; issue_word = wd;
    issue_csr_wen = cw; issue_csr_addr = ca; issue_pc = pc; issue_valid = 1'b1;
    cyc();
    issue_valid = 1'b0;
  endtask

  task automatic fin();
    exu_finish = 1'b1;
    cyc();
    exu_finish = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_trap_valid", 64'(trap_valid), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_hang", 64'(hang), 64'd0);
    cyc();
    rst = 1'b1;
    // word-sized alu result, one-cycle rf write
    issue(5'd5, 1'b1, 3'd0, 1'b1, 1'b0, 12'h0, 64'h1000);
    chk("t1_wait_ready", 64'(issue_ready), 64'd0);
    alu_out = 64'h0000_0001_8000_0000;
    fin();
    chk("t1_rf_wen", 64'(rf_wen), 64'd1);
    chk("t1_waddr", 64'(rf_waddr), 64'd5);
    chk("t1_wdata", rf_wdata, 64'hFFFF_FFFF_8000_0000);
    chk("t1_instret0", instret, 64'd0);
    cyc();
    chk("t1_rf_wen_once", 64'(rf_wen), 64'd0);
    chk("t1_cv_held", 64'(commit_valid), 64'd1);
    commit_ready = 1'b1;
    cyc();
    chk("t1_instret1", instret, 64'd1);
    chk("t1_cv_done", 64'(commit_valid), 64'd0);
    // link result with taken branch
    issue(5'd1, 1'b1, 3'd1, 1'b0, 1'b0, 12'h0, 64'h8000_0000);
    redirect_valid = 1'b1; br_out = 64'h8000_0100;
    fin();
    redirect_valid = 1'b0;
    chk("t2_wdata", rf_wdata, 64'h8000_0004);
    chk("t2_redirect", 64'(redirect_o), 64'd1);
    chk("t2_redirect_pc", redirect_pc, 64'h8000_0100);
    chk("t2_commit_pc", commit_pc, 64'h8000_0000);
    cyc();
    chk("t2_redirect_once", 64'(redirect_o), 64'd0);
    chk("t2_instret", instret, 64'd2);
    // csr write, rd=0 suppresses rf write
    issue(5'd0, 1'b1, 3'd5, 1'b0, 1'b1, 12'h305, 64'h100);
    csr_wdata_rd = 64'hAA; csr_wdata = 64'hBB;
    fin();
    chk("t4_rf_wen_rd0", 64'(rf_wen), 64'd0);
    chk("t4_csr_wen", 64'(csr_wen), 64'd1);
    chk("t4_csr_waddr", 64'(csr_waddr), 64'h305);
    chk("t4_csr_wdata", csr_wdata_o, 64'hBB);
    chk("t4_rf_wdata", rf_wdata, 64'hAA);
    cyc();
    chk("t4_csr_once", 64'(csr_wen), 64'd0);
    chk("t4_instret", instret, 64'd3);
    // exception suppresses every write
    issue(5'd3, 1'b1, 3'd0, 1'b0, 1'b1, 12'h300, 64'h200);
    redirect_valid = 1'b1; exu_exception = 64'h2;
    fin();
    redirect_valid = 1'b0; exu_exception = 64'h0;
    chk("t3_trap", 64'(trap_valid), 64'd1);
    chk("t3_cause", trap_cause, 64'h2);
    chk("t3_rf_wen", 64'(rf_wen), 64'd0);
    chk("t3_csr_wen", 64'(csr_wen), 64'd0);
    chk("t3_redirect", 64'(redirect_o), 64'd0);
    cyc();
    chk("t3_trap_once", 64'(trap_valid), 64'd0);
    chk("t3_instret", instret, 64'd3);
    // stalled commit followed by back-to-back issue
    commit_ready = 1'b0;
    issue(5'd7, 1'b1, 3'd4, 1'b0, 1'b0, 12'h0, 64'h2000);
    mul_out = 64'h1234;
    fin();
    for (int i = 0; i < 3; i++) begin
      chk("t5_cv_stall", 64'(commit_valid), 64'd1);
      chk("t5_pc_stall", commit_pc, 64'h2000);
      cyc();
    end
    commit_ready = 1'b1; issue_valid = 1'b1;
    issue_rd = 5'd8; issue_wbsel = 3'd2; issue_pc = 64'h3000; issue_csr_wen = 1'b0;
    #1;
    chk("t5_ready_commit", 64'(issue_ready), 64'd1);
    chk("t5_cv_4th", 64'(commit_valid), 64'd1);
    chk("t5_pc_4th", commit_pc, 64'h2000);
    chk("t5_mul", rf_wdata, 64'h1234);
    cyc();
    issue_valid = 1'b0;
    chk("t5_in_wait_ready", 64'(issue_ready), 64'd0);
    chk("t5_in_wait_cv", 64'(commit_valid), 64'd0);
    chk("t5_instret", instret, 64'd4);
    div_out = 64'h55;
    fin();
    chk("t5_rf_wen2", 64'(rf_wen), 64'd1);
    chk("t5_waddr2", 64'(rf_waddr), 64'd8);
    chk("t5_div", rf_wdata, 64'h55);
    chk("t5_pc2", commit_pc, 64'h3000);
    cyc();
    chk("t5_instret2", instret, 64'd5);
    // flush beats a simultaneous finish
    issue(5'd9, 1'b1, 3'd0, 1'b0, 1'b0, 12'h0, 64'h4000);
    flush = 1'b1;
    fin();
    flush = 1'b0;
    chk("t6_cv", 64'(commit_valid), 64'd0);
    chk("t6_rf_wen", 64'(rf_wen), 64'd0);
    chk("t6_idle", 64'(issue_ready), 64'd1);
    fin();
    chk("t6_stray_cv", 64'(commit_valid), 64'd0);
    chk("t6_stray_rf", 64'(rf_wen), 64'd0);
    chk("t6_instret", instret, 64'd5);
    // timeout after four WAIT cycles
    issue(5'd4, 1'b1, 3'd0, 1'b0, 1'b0, 12'h0, 64'h5000);
    cyc(); cyc(); cyc();
    chk("t7_no_hang_yet", 64'(hang), 64'd0);
    chk("t7_still_wait", 64'(issue_ready), 64'd0);
    cyc();
    chk("t7_hang", 64'(hang), 64'd1);
    chk("t7_idle", 64'(issue_ready), 64'd1);
    chk("t7_no_commit", 64'(commit_valid), 64'd0);
    issue(5'd2, 1'b1, 3'd0, 1'b0, 1'b0, 12'h0, 64'h6000);
    alu_out = 64'h7;
    fin();
    chk("t7_after_hang_wdata", rf_wdata, 64'h7);
    chk("t7_after_hang_wen", 64'(rf_wen), 64'd1);
    chk("t7_hang_sticky", 64'(hang), 64'd1);
    cyc();
    chk("t7_instret", instret, 64'd6);
    // asynchronous reset mid-WAIT
    issue(5'd6, 1'b1, 3'd0, 1'b0, 1'b0, 12'h0, 64'h7000);
    #2 rst = 1'b0;
    #1;
    chk("t8_rst_hang", 64'(hang), 64'd0);
    chk("t8_rst_instret", instret, 64'd0);
    chk("t8_rst_ready", 64'(issue_ready), 64'd1);
    cyc();
    rst = 1'b1;
    fin();
    chk("t8_no_commit", 64'(commit_valid), 64'd0);
    chk("t8_no_wen", 64'(rf_wen), 64'd0);
    chk("t8_instret", instret, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
